fetch_unit: RTL and testbench
=============================

# fetch_unit

Parametrised instruction-fetch unit for the single-cycle core: holds the PC and computes the next PC from the core's branch, call and return controls. Branch targets come from internal writable relative-offset and absolute-target tables, and call/return uses a hardware link stack. The unit sits between the controller/ALU-flags outputs and the instruction ROM address. It reports completion through DONE.

## Interface
Parameters:
- PC_W, 16, PC and target width.
- LUT_IW, 4, table index width; each table has 2^LUT_IW entries.
- STACK_DEPTH, 4, link-stack entries; must be at least 1.
- PROG_END, 'hFFFF, PC value at which DONE asserts.

Ports:
- CLK, input, 1, rising-edge clock.
- START, input, 1, synchronous active-high reset / program start.
- stall, input, 1, hold PC this cycle.
- branch_abs, input, 1, jump to absolute-table target.
- branch_rel_z, input, 1, relative branch if zero_flag=1.
- branch_rel_nz, input, 1, relative branch if zero_flag=0.
- call, input, 1, push PC+1, then jump to absolute-table target.
- ret, input, 1, pop the link stack into PC.
- zero_flag, input, 1, registered ALU zero flag.
- lut_idx, input, LUT_IW, table index for the current instruction.
- lut_we, input, 1, table write enable.
- lut_wsel, input, 1, selects the table to write: 0 = relative, 1 = absolute.
- lut_waddr, input, LUT_IW, table write address.
- lut_wdata, input, PC_W, table write data.
- PC, output, PC_W, current fetch address.
- DONE, output, 1, program finished.
- stack_err, output, 1, sticky link-stack overflow/underflow.

## Operation
- Both tables are register arrays. Reads are combinational on lut_idx; relative entries are signed two's-complement offsets.
- Next-PC priority is fixed, highest first:
  - START: PC=0.
  - DONE: PC holds.
  - stall: PC holds and no push/pop occurs.
  - ret: PC = top of stack; pop.
  - call: PC = abs[lut_idx]; push PC+1.
  - branch_abs: PC = abs[lut_idx].
  - branch_rel_z with zero_flag=1, or branch_rel_nz with zero_flag=0: PC = PC + rel[lut_idx].
  - Otherwise: PC+1.
- All PC arithmetic is modulo 2^PC_W. A relative offset is used at full PC_W width, so a negative entry branches backward, and 'hFFFF with PC=0 wraps to 'hFFFF.
- If both branch_rel_z and branch_rel_nz are set, the branch is taken unconditionally.
- Call on a full stack: no push, no jump, PC=PC+1, stack_err set.
- Ret on an empty stack: no pop, PC=PC+1, stack_err set.
- Simultaneous call and ret: ret wins; call is ignored.
- DONE is set on the edge where next-PC equals PROG_END. It stays set until START.
- lut_we is honoured during stall and while DONE is set. It is ignored while START is asserted.

## Timing
- PC, DONE and stack_err are registered and update on the CLK rising edge.
- Control inputs are combinational functions of the instruction at the current PC and are sampled on that same edge. Redirect latency is 1 cycle with no delay slot.
- A table write takes effect on the next cycle. A same-cycle read of the entry being written returns the old value.
- Reset values: PC=0, DONE=0, stack_err=0, stack pointer=0 (empty), all table entries 0.
- START mid-operation: the stack empties on the next edge, the tables clear, and an in-flight call or return is discarded.
- Push and pop each take one cycle. Stack occupancy ranges from 0 to STACK_DEPTH.

## Configuration
- FETCH_LINK_STACK_EN defined: the link stack, the call/ret paths and stack_err are compiled in as described above.
- FETCH_LINK_STACK_EN undefined: no stack storage is built. call behaves as branch_abs with no push. ret is ignored and gives PC+1. stack_err is tied to 0. STACK_DEPTH is unused.

## Test plan
- Reset then free-run with no controls, PROG_END=5: PC reads 0,1,2,3,4,5; DONE rises on the edge into PC=5 and PC holds at 5 for 3 further cycles.
- Write rel[3]='hFFFD; at PC=10 assert branch_rel_nz with zero_flag=0, lut_idx=3 -> PC=7. Repeat with zero_flag=1 -> PC=11.
- Write abs[2]=40; call at PC=8 -> PC=40. ret at PC=45 -> PC=9. stack_err stays 0.
- STACK_DEPTH=2: three nested calls -> third call gives PC+1 and stack_err=1. Then three rets -> the third ret gives PC+1 and stack_err stays 1.
- At PC=20, stall plus call for 2 cycles -> PC=20 with no push. Write abs[1]=99 and read lut_idx=1 in the same cycle -> jump uses the old value; the next-cycle branch_abs reaches 99.
- Assert START during a call, with two entries on the stack -> PC=0, DONE=0, stack_err=0. A subsequent ret underflows and sets stack_err.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch unit: PC register, next-PC select, writable branch tables and link stack.
// Build option: FETCH_LINK_STACK_EN compiles in the link stack, call/ret handling and stack_err.
module fetch_unit #(
  parameter int unsigned     PC_W        = 16,
  parameter int unsigned     LUT_IW      = 4,
  parameter int unsigned     STACK_DEPTH = 4,
  parameter logic [PC_W-1:0] PROG_END    = PC_W'(16'hFFFF)
) (
  input  logic              CLK,
  input  logic              START,
  input  logic              stall,
  input  logic              branch_abs,
  input  logic              branch_rel_z,
  input  logic              branch_rel_nz,
  input  logic              call,
  input  logic              ret,
  input  logic              zero_flag,
  input  logic [LUT_IW-1:0] lut_idx,
  input  logic              lut_we,
  input  logic              lut_wsel,
  input  logic [LUT_IW-1:0] lut_waddr,
  input  logic [PC_W-1:0]   lut_wdata,
  output logic [PC_W-1:0]   PC,
  output logic              DONE,
  output logic              stack_err
);

  if (STACK_DEPTH < 1) begin : g_bad_depth
    $error("fetch_unit: STACK_DEPTH must be at least 1");
  end

  logic [PC_W-1:0] rel_tab [2**LUT_IW];
  logic [PC_W-1:0] abs_tab [2**LUT_IW];
  logic [PC_W-1:0] pc_q, next_pc, pc_inc, abs_tgt, rel_tgt;
  logic            done_q, rel_take;

  always_comb begin
    pc_inc   = pc_q + PC_W'(1);
    abs_tgt  = abs_tab[lut_idx];
    rel_tgt  = pc_q + rel_tab[lut_idx];
    rel_take = (branch_rel_z && zero_flag) || (branch_rel_nz && !zero_flag);
  end

`ifdef FETCH_LINK_STACK_EN
  localparam int unsigned     SP_W   = $clog2(STACK_DEPTH + 1);
  localparam logic [SP_W-1:0] SP_MAX = SP_W'(STACK_DEPTH);

  // Storage is sized to the pointer range so sp can index it directly; only
  // entries below STACK_DEPTH are ever written.
  logic [PC_W-1:0] stack [2**SP_W];
  logic [SP_W-1:0] sp_q, sp_top;
  logic            push, pop, err_set, err_q;

  always_comb begin
    next_pc = pc_inc;
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
    sp_top  = sp_q - SP_W'(1);
    if (done_q || stall) begin
      next_pc = pc_q;
    end else if (ret) begin
      if (sp_q == '0) begin
        err_set = 1'b1;
      end else begin
        next_pc = stack[sp_top];
        pop     = 1'b1;
      end
    end else if (call) begin
      if (sp_q == SP_MAX) begin
        err_set = 1'b1;
      end else begin
        next_pc = abs_tgt;
        push    = 1'b1;
      end
    end else if (branch_abs) begin
      next_pc = abs_tgt;
    end else if (rel_take) begin
      next_pc = rel_tgt;
    end
  end

  always_ff @(posedge CLK) begin
    if (START) begin
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (push)     sp_q <= sp_q + SP_W'(1);
      else if (pop) sp_q <= sp_top;
      if (err_set)  err_q <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!START && push) stack[sp_q] <= pc_inc;
  end

  assign stack_err = err_q;
`else
  always_comb begin
    next_pc = pc_inc;
    if (done_q || stall) begin
      next_pc = pc_q;
    end else if (ret) begin
      next_pc = pc_inc;
    end else if (call || branch_abs) begin
      next_pc = abs_tgt;
    end else if (rel_take) begin
      next_pc = rel_tgt;
    end
  end

  assign stack_err = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (START) begin
      pc_q   <= '0;
      done_q <= 1'b0;
      for (int unsigned i = 0; i < 2**LUT_IW; i++) begin
        rel_tab[i] <= '0;
        abs_tab[i] <= '0;
      end
    end else begin
      pc_q <= next_pc;
      if (next_pc == PROG_END) done_q <= 1'b1;
      if (lut_we) begin
        if (lut_wsel) abs_tab[lut_waddr] <= lut_wdata;
        else          rel_tab[lut_waddr] <= lut_wdata;
      end
    end
  end

  assign PC   = pc_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit; expectations adapt to FETCH_LINK_STACK_EN.
module tb_fetch_unit;

`ifdef FETCH_LINK_STACK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  localparam logic [6:0] S   = 7'h01;
  localparam logic [6:0] BA  = 7'h02;
  localparam logic [6:0] BZ  = 7'h04;
  localparam logic [6:0] BNZ = 7'h08;
  localparam logic [6:0] CL  = 7'h10;
  localparam logic [6:0] RT  = 7'h20;
  localparam logic [6:0] ZF  = 7'h40;

  logic        CLK, START, stall, branch_abs, branch_rel_z, branch_rel_nz;
  logic        call, ret, zero_flag, lut_we, lut_wsel;
  logic [3:0]  lut_idx, lut_waddr;
  logic [15:0] lut_wdata;
  logic [15:0] pc_a, pc_b;
  logic        done_a, done_b, err_a, err_b;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_unit #(.PROG_END(16'd5)) dut_a (
    .CLK(CLK), .START(START), .stall(stall), .branch_abs(branch_abs),
    .branch_rel_z(branch_rel_z), .branch_rel_nz(branch_rel_nz), .call(call), .ret(ret),
    .zero_flag(zero_flag), .lut_idx(lut_idx), .lut_we(lut_we), .lut_wsel(lut_wsel),
    .lut_waddr(lut_waddr), .lut_wdata(lut_wdata), .PC(pc_a), .DONE(done_a), .stack_err(err_a)
  );

  fetch_unit #(.STACK_DEPTH(2)) dut_b (
    .CLK(CLK), .START(START), .stall(stall), .branch_abs(branch_abs),
    .branch_rel_z(branch_rel_z), .branch_rel_nz(branch_rel_nz), .call(call), .ret(ret),
    .zero_flag(zero_flag), .lut_idx(lut_idx), .lut_we(lut_we), .lut_wsel(lut_wsel),
    .lut_waddr(lut_waddr), .lut_wdata(lut_wdata), .PC(pc_b), .DONE(done_b), .stack_err(err_b)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [6:0]  ctl;
    logic [3:0]  idx;
    logic        we;
    logic        wsel;
    logic [3:0]  waddr;
    logic [15:0] wdata;
    logic [15:0] exp_pc;
    logic        exp_err;
  } vec_t;

  vec_t vt [32];

  function automatic vec_t mk(input logic [6:0] c, input logic [3:0] idx, input logic we,
                              input logic wsel, input logic [3:0] wa, input logic [15:0] wd,
                              input logic [15:0] pc, input logic err);
    vec_t v;
    v.ctl = c; v.idx = idx; v.we = we; v.wsel = wsel; v.waddr = wa; v.wdata = wd;
    v.exp_pc = pc; v.exp_err = err;
    return v;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [6:0] c, input logic [3:0] idx);
    stall = c[0]; branch_abs = c[1]; branch_rel_z = c[2]; branch_rel_nz = c[3];
    call = c[4]; ret = c[5]; zero_flag = c[6]; lut_idx = idx;
  endtask

  task automatic wr(input logic we, input logic wsel, input logic [3:0] wa, input logic [15:0] wd);
    lut_we = we; lut_wsel = wsel; lut_waddr = wa; lut_wdata = wd;
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    end
  endtask

  task automatic restart();
    drive('0, 4'd0);
    wr(1'b0, 1'b0, 4'd0, 16'd0);
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  logic [6:0]  sq_ctl [6];
  logic [15:0] sq_pc  [6];
  logic        sq_err [6];

  initial begin
    CLK = 1'b0;
    START = 1'b0;
    restart();
    chk16("reset pc_a", pc_a, 16'd0);
    chk1("reset done_a", done_a, 1'b0);
    chk1("reset err_a", err_a, 1'b0);
    chk16("reset pc_b", pc_b, 16'd0);
    chk1("reset done_b", done_b, 1'b0);
    chk1("reset err_b", err_b, 1'b0);

    // Free run into PROG_END=5 on dut_a, then hold
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk16("freerun pc", pc_a, 16'(i));
      chk1("freerun done", done_a, i == 5);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      chk16("hold pc", pc_a, 16'd5);
      chk1("hold done", done_a, 1'b1);
    end
    restart();
    chk1("start clears done", done_a, 1'b0);
    chk16("start clears pc", pc_a, 16'd0);

    vt[0]  = mk(7'h00, 4'd0, 1, 0, 4'd3, 16'hFFFD, 16'd1, 0);
    vt[1]  = mk(7'h00, 4'd0, 1, 1, 4'd0, 16'd10,   16'd2, 0);
    vt[2]  = mk(7'h00, 4'd0, 1, 1, 4'd2, 16'd40,   16'd3, 0);
    vt[3]  = mk(BA,        4'd0, 0, 0, 4'd0, 16'd0, 16'd10, 0);
    vt[4]  = mk(BNZ,       4'd3, 0, 0, 4'd0, 16'd0, 16'd7,  0);
    vt[5]  = mk(BA,        4'd0, 0, 0, 4'd0, 16'd0, 16'd10, 0);
    vt[6]  = mk(BNZ | ZF,  4'd3, 0, 0, 4'd0, 16'd0, 16'd11, 0);
    vt[7]  = mk(BZ | ZF,   4'd3, 0, 0, 4'd0, 16'd0, 16'd8,  0);
    vt[8]  = mk(CL,        4'd2, 0, 0, 4'd0, 16'd0, 16'd40, 0);
    vt[9]  = mk(7'h00,     4'd0, 0, 0, 4'd0, 16'd0, 16'd41, 0);
    vt[10] = mk(7'h00,     4'd0, 0, 0, 4'd0, 16'd0, 16'd42, 0);
    vt[11] = mk(7'h00,     4'd0, 0, 0, 4'd0, 16'd0, 16'd43, 0);
    vt[12] = mk(7'h00,     4'd0, 0, 0, 4'd0, 16'd0, 16'd44, 0);
    vt[13] = mk(7'h00,     4'd0, 0, 0, 4'd0, 16'd0, 16'd45, 0);
    vt[14] = mk(RT,        4'd0, 0, 0, 4'd0, 16'd0, STK ? 16'd9 : 16'd46, 0);
    vt[15] = mk(BZ | BNZ,      4'd3, 0, 0, 4'd0, 16'd0, STK ? 16'd6 : 16'd43, 0);
    vt[16] = mk(BZ | BNZ | ZF, 4'd3, 0, 0, 4'd0, 16'd0, STK ? 16'd3 : 16'd40, 0);
    vt[17] = mk(7'h00,     4'd0, 1, 1, 4'd6, 16'hFFF0, STK ? 16'd4 : 16'd41, 0);
    vt[18] = mk(7'h00,     4'd0, 1, 0, 4'd7, 16'h0020, STK ? 16'd5 : 16'd42, 0);
    vt[19] = mk(BA,        4'd6, 0, 0, 4'd0, 16'd0, 16'hFFF0, 0);
    vt[20] = mk(BZ | ZF,   4'd7, 0, 0, 4'd0, 16'd0, 16'h0010, 0);
    vt[21] = mk(7'h00,     4'd0, 1, 1, 4'd8, 16'd20, 16'd17, 0);
    vt[22] = mk(BA,        4'd8, 0, 0, 4'd0, 16'd0, 16'd20, 0);
    vt[23] = mk(S | CL,    4'd2, 0, 0, 4'd0, 16'd0, 16'd20, 0);
    vt[24] = mk(S | CL,    4'd2, 0, 0, 4'd0, 16'd0, 16'd20, 0);
    vt[25] = mk(BA,        4'd1, 1, 1, 4'd1, 16'd99, 16'd0, 0);
    vt[26] = mk(BA,        4'd1, 0, 0, 4'd0, 16'd0, 16'd99, 0);
    vt[27] = mk(CL | RT,   4'd2, 0, 0, 4'd0, 16'd0, 16'd100, STK);
    vt[28] = mk(RT,        4'd0, 0, 0, 4'd0, 16'd0, 16'd101, STK);
    vt[29] = mk(S,         4'd0, 1, 1, 4'd9, 16'd77, 16'd101, STK);
    vt[30] = mk(BA,        4'd9, 0, 0, 4'd0, 16'd0, 16'd77, STK);
    vt[31] = mk(BZ,        4'd3, 0, 0, 4'd0, 16'd0, 16'd78, STK);

    for (int i = 0; i < 32; i++) begin
      drive(vt[i].ctl, vt[i].idx);
      wr(vt[i].we, vt[i].wsel, vt[i].waddr, vt[i].wdata);
      tick();
      chk16($sformatf("vec%0d pc", i), pc_b, vt[i].exp_pc);
      chk1($sformatf("vec%0d err", i), err_b, vt[i].exp_err);
      chk1($sformatf("vec%0d done", i), done_b, 1'b0);
    end

    // Nested calls against a 2-deep stack, then unwind past empty
    restart();
    wr(1'b1, 1'b1, 4'd0, 16'd50);
    tick();
    wr(1'b0, 1'b0, 4'd0, 16'd0);
    chk16("ovf setup pc", pc_b, 16'd1);
    sq_ctl = '{CL, CL, CL, RT, RT, RT};
    if (STK) begin
      sq_pc  = '{16'd50, 16'd50, 16'd51, 16'd51, 16'd2, 16'd3};
      sq_err = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    end else begin
      sq_pc  = '{16'd50, 16'd50, 16'd50, 16'd51, 16'd52, 16'd53};
      sq_err = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    end
    for (int i = 0; i < 6; i++) begin
      drive(sq_ctl[i], 4'd0);
      tick();
      chk16($sformatf("ovf%0d pc", i), pc_b, sq_pc[i]);
      chk1($sformatf("ovf%0d err", i), err_b, sq_err[i]);
    end

    // START while a call is in flight with two entries stacked
    restart();
    wr(1'b1, 1'b1, 4'd0, 16'd30);
    tick();
    wr(1'b0, 1'b0, 4'd0, 16'd0);
    drive(CL, 4'd0);
    tick();
    chk16("midstart call1", pc_b, 16'd30);
    tick();
    chk16("midstart call2", pc_b, 16'd30);
    START = 1'b1;
    tick();
    START = 1'b0;
    chk16("midstart pc", pc_b, 16'd0);
    chk1("midstart done", done_b, 1'b0);
    chk1("midstart err", err_b, 1'b0);
    drive(BA, 4'd0);
    tick();
    chk16("midstart table cleared", pc_b, 16'd0);
    drive(RT, 4'd0);
    tick();
    chk16("post-start ret pc", pc_b, 16'd1);
    chk1("post-start ret err", err_b, STK);
    drive('0, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
